// File: rtl/arbiter_pkg.sv
// Shared definitions for the common-bus arbiter.
//   arb_state_e : arbiter FSM states (IDLE, PROC, SNOOP, MEM)
//   idx_w()     : index width for an N-entry vector (never below 1 bit).
//                 PROC_W = idx_w(NUM_PROC), SNOOP_W = idx_w(NUM_SNOOP).
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROC  = 2'd1,
    SNOOP = 2'd2,
    MEM   = 2'd3
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_order_fifo.sv
// Arrival-order queue of processor indices.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   push, push_data   : enqueue one index (ignored when full unless popping)
//   pop, pop_data     : dequeue head; pop_data shows the head combinationally
//   empty, full       : occupancy flags
//   count             : occupancy register
module req_order_fifo
  import arbiter_pkg::*;
#(
  parameter int unsigned Depth  = 8,
  parameter int unsigned Width  = 3,
  localparam int unsigned PtrW  = idx_w(Depth),
  localparam int unsigned CntW  = idx_w(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(Depth));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written.
  assign push_ok  = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter: grants the bus to processors in request-arrival order and,
// within each tenure, at most one snoop response (snoop agent or memory).
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   proc_req / proc_gnt          : level processor requests / one-hot grant
//   snoop_req / snoop_gnt        : snoop-agent requests / one-hot grant
//   mem_snoop_req / mem_snoop_gnt: memory snoop request / grant
//   owner, busy                  : granted processor index, tenure active
//   q_count                      : order-queue occupancy
//   timeout_evt                  : one-cycle pulse on watchdog release
module com_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PROC   = 8,
  parameter int unsigned NUM_SNOOP  = 4,
  parameter int unsigned MAX_HOLD   = 64,
  parameter int unsigned MEM_FIRST  = 0,
  localparam int unsigned PROC_W    = idx_w(NUM_PROC),
  localparam int unsigned SNOOP_W   = idx_w(NUM_SNOOP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PROC-1:0]  proc_req,
  output logic [NUM_PROC-1:0]  proc_gnt,
  input  logic [NUM_SNOOP-1:0] snoop_req,
  output logic [NUM_SNOOP-1:0] snoop_gnt,
  input  logic                 mem_snoop_req,
  output logic                 mem_snoop_gnt,
  output logic [PROC_W-1:0]    owner,
  output logic                 busy,
  output logic [PROC_W:0]      q_count,
  output logic                 timeout_evt
);

  localparam int unsigned CoreProcs = NUM_PROC / NUM_SNOOP;
  localparam int unsigned HoldW     = idx_w(MAX_HOLD + 1);
  localparam int unsigned HoldLast  = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_e           state_q, state_d;
  logic [NUM_PROC-1:0]  req_prev_q, pending_q, pending_d, cand;
  logic [NUM_PROC-1:0]  proc_gnt_q, proc_gnt_d;
  logic [NUM_SNOOP-1:0] snoop_gnt_q, snoop_gnt_d, eligible;
  logic                 mem_gnt_q, mem_gnt_d;
  logic [PROC_W-1:0]    owner_q, owner_d, push_idx, head;
  logic                 busy_q, busy_d, timeout_q, timeout_d;
  logic                 used_q, used_d;
  logic [SNOOP_W-1:0]   ptr_q, ptr_d, snoop_idx_q, snoop_idx_d, win_idx, owner_core;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic                 push_valid, push, pop, fifo_empty, fifo_full;
  logic                 win_valid, grant_mem, expired;
  int unsigned          rr_idx;

  req_order_fifo #(
    .Depth (NUM_PROC),
    .Width (PROC_W)
  ) u_order_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_idx),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (q_count)
  );

  assign pop = (state_q == IDLE) & ~fifo_empty;

  // Rising edges join the pending set; the lowest pending index is queued each cycle.
  always_comb begin
    cand       = pending_q | (proc_req & ~req_prev_q);
    push_valid = 1'b0;
    push_idx   = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        push_valid = 1'b1;
        push_idx   = PROC_W'(i);
      end
    end
    push      = push_valid & (~fifo_full | pop);
    pending_d = cand;
    if (push) pending_d[push_idx] = 1'b0;
  end

  // Round-robin pick among snoop agents outside the owner's core.
  always_comb begin
    owner_core = SNOOP_W'(32'(owner_q) / CoreProcs);
    eligible   = snoop_req;
    eligible[owner_core] = 1'b0;
    win_valid  = 1'b0;
    win_idx    = '0;
    rr_idx     = 0;
    for (int i = 0; i < NUM_SNOOP; i++) begin
      rr_idx = int'(ptr_q) + i;
      if (rr_idx >= NUM_SNOOP) rr_idx = rr_idx - NUM_SNOOP;
      if (!win_valid && eligible[SNOOP_W'(rr_idx)]) begin
        win_valid = 1'b1;
        win_idx   = SNOOP_W'(rr_idx);
      end
    end
    grant_mem = mem_snoop_req & ((MEM_FIRST != 0) | ~win_valid);
    expired   = (MAX_HOLD != 0) && (hold_q == HoldW'(HoldLast));
  end

  always_comb begin
    state_d     = state_q;
    proc_gnt_d  = proc_gnt_q;
    snoop_gnt_d = snoop_gnt_q;
    mem_gnt_d   = mem_gnt_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    timeout_d   = 1'b0;
    used_d      = used_q;
    ptr_d       = ptr_q;
    snoop_idx_d = snoop_idx_q;
    hold_d      = hold_q;
    unique case (state_q)
      IDLE: begin
        // A withdrawn head is popped and dropped without a grant.
        if (pop && proc_req[head]) begin
          proc_gnt_d       = '0;
          proc_gnt_d[head] = 1'b1;
          owner_d          = head;
          busy_d           = 1'b1;
          used_d           = 1'b0;
          hold_d           = '0;
          state_d          = PROC;
        end
      end
      PROC: begin
        if (!proc_req[owner_q] || expired) begin
          proc_gnt_d = '0;
          busy_d     = 1'b0;
          timeout_d  = proc_req[owner_q];
          state_d    = IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
          if (!used_q && grant_mem) begin
            mem_gnt_d = 1'b1;
            state_d   = MEM;
          end else if (!used_q && win_valid) begin
            snoop_gnt_d          = '0;
            snoop_gnt_d[win_idx] = 1'b1;
            snoop_idx_d          = win_idx;
            ptr_d   = (win_idx == SNOOP_W'(NUM_SNOOP - 1)) ? '0 : win_idx + 1'b1;
            state_d = SNOOP;
          end
        end
      end
      SNOOP: begin
        if (!snoop_req[snoop_idx_q]) begin
          snoop_gnt_d = '0;
          used_d      = 1'b1;
          state_d     = PROC;
        end
      end
      MEM: begin
        if (!mem_snoop_req) begin
          mem_gnt_d = 1'b0;
          used_d    = 1'b1;
          state_d   = PROC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_prev_q  <= '0;
      pending_q   <= '0;
      proc_gnt_q  <= '0;
      snoop_gnt_q <= '0;
      mem_gnt_q   <= 1'b0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      used_q      <= 1'b0;
      ptr_q       <= '0;
      snoop_idx_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_prev_q  <= proc_req;
      pending_q   <= pending_d;
      proc_gnt_q  <= proc_gnt_d;
      snoop_gnt_q <= snoop_gnt_d;
      mem_gnt_q   <= mem_gnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      used_q      <= used_d;
      ptr_q       <= ptr_d;
      snoop_idx_q <= snoop_idx_d;
      hold_q      <= hold_d;
    end
  end

  assign proc_gnt      = proc_gnt_q;
  assign snoop_gnt     = snoop_gnt_q;
  assign mem_snoop_gnt = mem_gnt_q;
  assign owner         = owner_q;
  assign busy          = busy_q;
  assign timeout_evt   = timeout_q;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: two instances (watchdog 12 / snoop-first and
// watchdog 4 / memory-first) share random stimulus and are compared every
// cycle against a queue-based reference model, plus directed scenarios.
module tb_com_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] proc_req;
  logic [3:0] snoop_req;
  logic       mem_snoop_req;

  logic [7:0] pg0, pg1;
  logic [3:0] sg0, sg1;
  logic       mg0, mg1, bz0, bz1, to0, to1;
  logic [2:0] ow0, ow1;
  logic [3:0] qc0, qc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  com_bus_arbiter #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(12), .MEM_FIRST(0)) dut0 (
    .clk(clk), .rst(rst), .proc_req(proc_req), .proc_gnt(pg0), .snoop_req(snoop_req),
    .snoop_gnt(sg0), .mem_snoop_req(mem_snoop_req), .mem_snoop_gnt(mg0), .owner(ow0),
    .busy(bz0), .q_count(qc0), .timeout_evt(to0)
  );

  com_bus_arbiter #(.NUM_PROC(8), .NUM_SNOOP(4), .MAX_HOLD(4), .MEM_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .proc_req(proc_req), .proc_gnt(pg1), .snoop_req(snoop_req),
    .snoop_gnt(sg1), .mem_snoop_req(mem_snoop_req), .mem_snoop_gnt(mg1), .owner(ow1),
    .busy(bz1), .q_count(qc1), .timeout_evt(to1)
  );

  // Reference model state, one slot per instance.
  int         m_hold_max [2] = '{12, 4};
  bit         m_mem_first[2] = '{1'b0, 1'b1};
  logic [7:0] m_prev[2], m_pend[2];
  int         m_q[2][8];
  int         m_qn[2], m_owner[2], m_sn[2], m_hold[2], m_ptr[2];
  bit         m_mem[2], m_used[2], m_to[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_prev[k] = '0; m_pend[k] = '0; m_qn[k] = 0; m_owner[k] = -1; m_sn[k] = -1;
    m_hold[k] = 0; m_ptr[k] = 0; m_mem[k] = 1'b0; m_used[k] = 1'b0; m_to[k] = 1'b0;
  endtask

  task automatic model_step(input int k, input logic [7:0] r, input logic [3:0] s,
                            input logic m);
    logic [7:0] cand;
    logic [3:0] elig;
    int head, lo, core, j;
    bit popped;
    cand   = m_pend[k] | (r & ~m_prev[k]);
    popped = 1'b0;
    head   = 0;
    if (m_owner[k] < 0 && m_qn[k] > 0) begin
      head = m_q[k][0];
      for (int i = 0; i < 7; i++) m_q[k][i] = m_q[k][i+1];
      m_qn[k]--;
      popped = 1'b1;
    end
    lo = -1;
    for (int i = 7; i >= 0; i--) if (cand[i]) lo = i;
    if (lo >= 0 && m_qn[k] < 8) begin
      m_q[k][m_qn[k]] = lo;
      m_qn[k]++;
      cand[lo[2:0]] = 1'b0;
    end
    m_pend[k] = cand;
    m_prev[k] = r;
    m_to[k]   = 1'b0;
    if (m_owner[k] < 0) begin
      if (popped && r[head[2:0]]) begin
        m_owner[k] = head; m_used[k] = 1'b0; m_hold[k] = 0;
      end
    end else if (m_sn[k] >= 0) begin
      j = m_sn[k];
      if (!s[j[1:0]]) begin m_sn[k] = -1; m_used[k] = 1'b1; end
    end else if (m_mem[k]) begin
      if (!m) begin m_mem[k] = 1'b0; m_used[k] = 1'b1; end
    end else begin
      j = m_owner[k];
      if (!r[j[2:0]]) m_owner[k] = -1;
      else if (m_hold_max[k] != 0 && m_hold[k] == m_hold_max[k] - 1) begin
        m_owner[k] = -1; m_to[k] = 1'b1;
      end else begin
        m_hold[k]++;
        if (!m_used[k]) begin
          elig = s;
          core = m_owner[k] / 2;
          elig[core[1:0]] = 1'b0;
          if (m_mem_first[k] && m) m_mem[k] = 1'b1;
          else if (elig != 4'b0) begin
            for (int i = 0; i < 4; i++) begin
              j = (m_ptr[k] + i) % 4;
              if (m_sn[k] < 0 && elig[j[1:0]]) m_sn[k] = j;
            end
            m_ptr[k] = (m_sn[k] + 1) % 4;
          end else if (m) m_mem[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_dut(input int k, input logic [7:0] pg, input logic [3:0] sg,
                             input logic mg, input logic [2:0] ow, input logic bz,
                             input logic [3:0] qc, input logic to);
    string p;
    p = $sformatf("d%0d_", k);
    check_eq({p, "proc_gnt"}, 32'(pg), (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0);
    check_eq({p, "snoop_gnt"}, 32'(sg), (m_sn[k] >= 0) ? (32'd1 << m_sn[k]) : 32'd0);
    check_eq({p, "mem_gnt"}, 32'(mg), 32'(m_mem[k]));
    check_eq({p, "busy"}, 32'(bz), 32'(m_owner[k] >= 0));
    check_eq({p, "q_count"}, 32'(qc), 32'(m_qn[k]));
    check_eq({p, "timeout"}, 32'(to), 32'(m_to[k]));
    if (m_owner[k] >= 0) check_eq({p, "owner"}, 32'(ow), 32'(m_owner[k]));
  endtask

  // Compare current outputs, drive the next inputs, advance the model, wait one cycle.
  task automatic step(input logic [7:0] r, input logic [3:0] s, input logic m);
    compare_dut(0, pg0, sg0, mg0, ow0, bz0, qc0, to0);
    compare_dut(1, pg1, sg1, mg1, ow1, bz1, qc1, to1);
    proc_req = r; snoop_req = s; mem_snoop_req = m;
    model_step(0, r, s, m);
    model_step(1, r, s, m);
    @(negedge clk);
  endtask

  task automatic rand_step();
    logic [7:0] r;
    logic [3:0] s;
    logic m;
    r = proc_req; s = snoop_req; m = mem_snoop_req;
    for (int i = 0; i < 8; i++)
      if (r[i] ? ($urandom_range(11) == 0) : ($urandom_range(15) == 0)) r[i] = ~r[i];
    for (int i = 0; i < 4; i++) if ($urandom_range(4) == 0) s[i] = ~s[i];
    if ($urandom_range(5) == 0) m = ~m;
    step(r, s, m);
  endtask

  initial begin
    bit found;
    rst = 1'b0; proc_req = '0; snoop_req = '0; mem_snoop_req = 1'b0;
    model_reset(0); model_reset(1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single request: push on first edge, grant after the second.
    step(8'h20, 4'h0, 1'b0);
    check_eq("single_qcount", 32'(qc0), 32'd1);
    check_eq("single_no_gnt_yet", 32'(pg0), 32'h0);
    step(8'h20, 4'h0, 1'b0);
    check_eq("single_gnt", 32'(pg0), 32'h20);
    check_eq("single_owner", 32'(ow0), 32'd5);
    repeat (3) step(8'h20, 4'h0, 1'b0);
    step(8'h00, 4'h0, 1'b0);
    check_eq("single_release", 32'(pg0), 32'h0);

    // Snoop exclusion: owner 2 (core 1) sees agents 0,1 -> agent 0 only.
    step(8'h04, 4'h0, 1'b0);
    step(8'h04, 4'h0, 1'b0);
    check_eq("snp_owner_gnt", 32'(pg0), 32'h04);
    step(8'h04, 4'b0011, 1'b0);
    check_eq("snp_excl", 32'(sg0), 32'b0001);
    step(8'h04, 4'b0000, 1'b0);
    check_eq("snp_drop", 32'(sg0), 32'h0);
    step(8'h04, 4'b0001, 1'b0);
    check_eq("snp_once_a", 32'(sg0), 32'h0);
    step(8'h04, 4'b0001, 1'b0);
    check_eq("snp_once_b", 32'(sg0), 32'h0);
    step(8'h00, 4'h0, 1'b0);

    // Round robin: pointer now at 1, owner 6 (core 3).
    step(8'h40, 4'h0, 1'b0);
    step(8'h40, 4'h0, 1'b0);
    step(8'h40, 4'b0011, 1'b0);
    check_eq("snp_rr", 32'(sg0), 32'b0010);
    step(8'h00, 4'h0, 1'b0);
    step(8'h00, 4'h0, 1'b0);
    check_eq("rr_release", 32'(pg0), 32'h0);
    step(8'h00, 4'h0, 1'b0);

    // Watchdog on dut1 (limit 4); proc 3 queued behind proc 1.
    for (int i = 0; i < 6; i++) step(8'h0A, 4'h0, 1'b0);
    check_eq("wd_release", 32'(pg1), 32'h0);
    check_eq("wd_pulse", 32'(to1), 32'd1);
    step(8'h0A, 4'h0, 1'b0);
    check_eq("wd_next_gnt", 32'(pg1), 32'h08);
    check_eq("wd_pulse_end", 32'(to1), 32'd0);
    // Withdrawal: dut0 still holds proc 3 queued, which is skipped.
    step(8'h00, 4'h0, 1'b0);
    check_eq("wdraw_queued", 32'(qc0), 32'd1);
    step(8'h00, 4'h0, 1'b0);
    check_eq("wdraw_no_gnt", 32'(pg0), 32'h0);
    check_eq("wdraw_popped", 32'(qc0), 32'd0);
    step(8'h00, 4'h0, 1'b0);

    // Priority: owner 4; memory first on dut1, agent first on dut0.
    step(8'h10, 4'h0, 1'b0);
    step(8'h10, 4'h0, 1'b0);
    step(8'h10, 4'b0001, 1'b1);
    check_eq("prio_mem_first", 32'(mg1), 32'd1);
    check_eq("prio_mem_first_sn", 32'(sg1), 32'h0);
    check_eq("prio_snoop_first", 32'(sg0), 32'b0001);
    check_eq("prio_snoop_first_mem", 32'(mg0), 32'd0);
    step(8'h10, 4'b0001, 1'b0);
    check_eq("prio_mem_drop", 32'(mg1), 32'd0);
    step(8'h10, 4'b0001, 1'b0);
    check_eq("prio_no_second", 32'(sg1), 32'h0);
    repeat (3) step(8'h00, 4'h0, 1'b0);

    // Ordering: 6, 1, 3 rise in successive cycles; then 2 and 4 together.
    step(8'h40, 4'h0, 1'b0);
    step(8'h42, 4'h0, 1'b0);
    repeat (4) step(8'h4A, 4'h0, 1'b0);
    repeat (3) step(8'h0A, 4'h0, 1'b0);
    repeat (3) step(8'h08, 4'h0, 1'b0);
    repeat (2) step(8'h00, 4'h0, 1'b0);
    repeat (4) step(8'h14, 4'h0, 1'b0);
    repeat (3) step(8'h10, 4'h0, 1'b0);
    repeat (3) step(8'h00, 4'h0, 1'b0);

    repeat (3000) rand_step();

    // Asynchronous reset while a snoop grant is active.
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      rand_step();
      if (sg0 != 4'h0) found = 1'b1;
    end
    check_eq("find_snoop_tenure", 32'(found), 32'd1);
    #2;
    rst = 1'b0; proc_req = '0; snoop_req = '0; mem_snoop_req = 1'b0;
    #1;
    check_eq("rst_proc_gnt", 32'({pg0, pg1}), 32'h0);
    check_eq("rst_snoop_gnt", 32'({sg0, sg1}), 32'h0);
    check_eq("rst_mem_gnt", 32'({mg0, mg1}), 32'h0);
    check_eq("rst_busy", 32'({bz0, bz1}), 32'h0);
    check_eq("rst_qcount", 32'({qc0, qc1}), 32'h0);
    check_eq("rst_timeout", 32'({to0, to1}), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset(0); model_reset(1);

    repeat (1500) rand_step();
    step(8'h00, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
